// File: rtl/mux_nx1_pipe.sv
// rtl/mux_nx1_pipe.sv - N:1 registered mux with valid/ready handshake and two-entry skid buffer
module mux_nx1_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clock_in,
  input  logic                    reset_n_in,
  input  logic [NUM_IN*WIDTH-1:0] values_in,
  input  logic [SEL_W-1:0]        select_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  output logic [WIDTH-1:0]        value_out,
  output logic [SEL_W-1:0]        sel_out,
  output logic                    err_out,
  output logic                    valid_out,
  input  logic                    ready_in
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   main_data, skid_data;
  logic [SEL_W-1:0]   main_sel, skid_sel;
  logic               main_err, skid_err;
  logic [WIDTH-1:0]   word_data;
  logic               word_err;
  logic               accept, deliver;

  // Any select that matches no real input leaves the data zero and flags err.
  always_comb begin
    word_data = '0;
    word_err  = 1'b1;
    for (int i = 0; i < NUM_IN; i++) begin
      if (select_in == SEL_W'(i)) begin
        word_data = values_in[i*WIDTH +: WIDTH];
        word_err  = 1'b0;
      end
    end
  end

  assign ready_out = (state != TWO);
  assign valid_out = (state != EMPTY);
  assign accept    = valid_in && ready_out;
  assign deliver   = valid_out && ready_in;

  assign value_out = main_data;
  assign sel_out   = main_sel;
  assign err_out   = main_err;

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state     <= EMPTY;
      main_data <= '0;
      main_sel  <= '0;
      main_err  <= 1'b0;
      skid_data <= '0;
      skid_sel  <= '0;
      skid_err  <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_data <= word_data;
            main_sel  <= select_in;
            main_err  <= word_err;
            state     <= ONE;
          end
        end
        ONE: begin
          case ({deliver, accept})
            2'b11: begin
              main_data <= word_data;
              main_sel  <= select_in;
              main_err  <= word_err;
            end
            2'b10: state <= EMPTY;
            2'b01: begin
              skid_data <= word_data;
              skid_sel  <= select_in;
              skid_err  <= word_err;
              state     <= TWO;
            end
            default: ;
          endcase
        end
        TWO: begin
          // ready_out is low here, so only the skid-to-main move can happen.
          if (deliver) begin
            main_data <= skid_data;
            main_sel  <= skid_sel;
            main_err  <= skid_err;
            skid_data <= '0;
            skid_sel  <= '0;
            skid_err  <= 1'b0;
            state     <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule
